// File: rtl/imem_loader_pkg.sv
// Shared CPU constants and loader state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: instruction memory DEPTH/ADDR_W (also used by fetch), loader
// state enum, and the program-length bounds check.
package imem_loader_pkg;

    localparam int DEPTH  = 32;          // instruction memory depth in words
    localparam int ADDR_W = 5;           // 2**ADDR_W >= DEPTH
    localparam int CNT_W  = ADDR_W + 1;  // wide enough to hold N == DEPTH

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COUNT,
        LD_BYTES,
        LD_WRITE,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    // A program must hold at least one word and fit in the memory.
    function automatic logic count_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= 8'(DEPTH));
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bundle: byte stream in, imem write port out, load status out.
// Latency: n/a (wiring only).
// Backpressure: stream uses valid/ready; the write port has no backpressure.
// Signals: start, in_data/in_valid/in_ready, mem_we/mem_addr/mem_wdata,
// busy, done, err, cpu_hold. master = host/fetch side, slave = loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold
    );

endinterface

// File: rtl/imem_loader.sv
// Loads a count/data/checksum byte stream into instruction memory, big-endian words.
// Latency: 4th byte of a word on edge k -> mem_we in cycle k+1; checksum on edge c -> done/err in c+1.
// Backpressure: in_ready drops in WRITE and outside a load; in_valid low simply stalls.
// Ports: clk, rst (async, active high), bus (imem_loader_if.slave).
// All outputs come from registered state; nothing combinational from in_valid.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    ld_state_t         state;
    ld_state_t         state_nxt;
    logic [CNT_W-1:0]  word_total;   // N captured from the count byte
    logic [ADDR_W-1:0] word_cnt;     // address of the word being assembled/written
    logic [1:0]        byte_idx;     // position within the current word
    logic [31:0]       asm_word;     // shift register, first byte ends up in MSBs
    logic [7:0]        xor_acc;      // running XOR of data bytes only
    logic              take;
    logic              last_word;

    assign take      = bus.in_valid && bus.in_ready;
    // Compare the post-increment count so the WRITE cycle picks CSUM directly.
    assign last_word = (({1'b0, word_cnt} + CNT_W'(1)) == word_total);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (bus.start) state_nxt = LD_COUNT;
            end
            LD_COUNT: begin
                if (take) state_nxt = count_ok(bus.in_data) ? LD_BYTES : LD_ERR;
            end
            LD_BYTES: begin
                if (take && (byte_idx == 2'd3)) state_nxt = LD_WRITE;
            end
            LD_WRITE: begin
                state_nxt = last_word ? LD_CSUM : LD_BYTES;
            end
            LD_CSUM: begin
                if (take) state_nxt = (bus.in_data == xor_acc) ? LD_DONE : LD_ERR;
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    // Output decode from registered state and datapath registers
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.cpu_hold  = 1'b1;
        bus.mem_addr  = word_cnt;
        bus.mem_wdata = asm_word;
        unique case (state)
            LD_COUNT, LD_BYTES, LD_CSUM: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
            end
            LD_WRITE: begin
                bus.mem_we = 1'b1;
                bus.busy   = 1'b1;
            end
            LD_DONE: begin
                bus.done     = 1'b1;
                bus.cpu_hold = 1'b0;
            end
            LD_ERR: begin
                bus.err = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: word counter, byte index, assembly register, checksum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_total <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            asm_word   <= '0;
            xor_acc    <= '0;
        end else begin
            unique case (state)
                LD_COUNT: begin
                    if (take && count_ok(bus.in_data)) begin
                        word_total <= bus.in_data[CNT_W-1:0];
                        word_cnt   <= '0;
                        byte_idx   <= '0;
                        xor_acc    <= '0;
                    end
                end
                LD_BYTES: begin
                    if (take) begin
                        asm_word <= {asm_word[23:0], bus.in_data};
                        xor_acc  <= xor_acc ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                LD_WRITE: begin
                    word_cnt <= word_cnt + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor
// pops and compares on every mem_we; load status checked after each load.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if bus();

    imem_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int         vectors     = 0;
    int         miscompares = 0;
    wr_t        exp_q[$];
    logic [7:0] data_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                chk("ready_low_in_write", 32'(bus.in_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr %0d data %h, expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("wr_data", bus.mem_wdata, e.data);
                end
            end
        end
    end

    // Reference model: words are the data bytes taken four at a time, MSB first.
    task automatic push_expected(input int nwords);
        for (int w = 0; w < nwords; w++) begin
            wr_t e;
            e.addr = w[ADDR_W-1:0];
            e.data = {data_q[4*w], data_q[4*w+1], data_q[4*w+2], data_q[4*w+3]};
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [7:0] ref_xor();
        logic [7:0] x = 8'h00;
        foreach (data_q[i]) x = x ^ data_q[i];
        return x;
    endfunction

    task automatic fill_random(input int nwords);
        data_q.delete();
        for (int i = 0; i < 4*nwords; i++) data_q.push_back(8'($urandom));
    endtask

    // Called at posedge+1; returns at posedge+1 just after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int   guard = 0;
        logic rdy   = 1'b0;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!rdy && guard < 300) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            guard++;
        end
        #1;
        bus.in_valid = 1'b0;
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_timeout: in_ready never seen high, required high within 300 cycles");
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_hold", 32'(bus.cpu_hold), 32'd1);
        chk("start_done", 32'(bus.done), 32'd0);
        chk("start_err",  32'(bus.err), 32'd0);
    endtask

    task automatic check_end(input bit exp_done, input bit exp_err);
        chk("end_done",  32'(bus.done), 32'(exp_done));
        chk("end_err",   32'(bus.err), 32'(exp_err));
        chk("end_hold",  32'(bus.cpu_hold), 32'(!exp_done));
        chk("end_busy",  32'(bus.busy), 32'd0);
        chk("end_ready", 32'(bus.in_ready), 32'd0);
    endtask

    // Bytes offered after a terminal state must not be taken.
    task automatic offer_stray_bytes();
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ready", 32'(bus.in_ready), 32'd0);
            chk("stray_busy",  32'(bus.busy), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // start_at: data-byte index before which a start is pulsed (-1 for none).
    task automatic run_load(input logic [7:0] n_byte, input logic [7:0] csum,
                            input bit gaps, input int start_at);
        bit cnt_ok = (n_byte != 8'd0) && (int'(n_byte) <= DEPTH);
        bit ok;
        do_start();
        if (cnt_ok) push_expected(int'(n_byte));
        send_byte(n_byte, gaps);
        if (!cnt_ok) begin
            check_end(1'b0, 1'b1);
            offer_stray_bytes();
            chk("end_err_held", 32'(bus.err), 32'd1);
        end else begin
            for (int i = 0; i < data_q.size(); i++) begin
                if (i == start_at) begin
                    bus.start = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.start = 1'b0;
                    chk("ignored_start_busy", 32'(bus.busy), 32'd1);
                end
                send_byte(data_q[i], gaps);
            end
            send_byte(csum, gaps);
            ok = (csum == ref_xor());
            check_end(ok, !ok);
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
        chk({tag, "_mem_we"},    32'(bus.mem_we), 32'd0);
        chk({tag, "_busy"},      32'(bus.busy), 32'd0);
        chk({tag, "_done"},      32'(bus.done), 32'd0);
        chk({tag, "_err"},       32'(bus.err), 32'd0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_cpu_hold"},  32'(bus.cpu_hold), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] cs;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal load, then the same stream with gaps, then a bad checksum.
        data_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
        run_load(8'd2, 8'h2C, 1'b0, -1);
        run_load(8'd2, 8'h2C, 1'b1, -1);
        run_load(8'd2, 8'h2D, 1'b1, -1);

        // Count bounds.
        data_q.delete();
        run_load(8'd0, 8'h00, 1'b0, -1);
        run_load(8'd33, 8'h00, 1'b0, -1);
        fill_random(32);
        run_load(8'd32, ref_xor(), 1'b1, -1);

        // Reset after 6 data bytes: only word 0 lands.
        fill_random(4);
        do_start();
        push_expected(1);
        send_byte(8'd4, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(data_q[i], 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_sb_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Full load after reset with a start pulsed mid-stream, then a reload.
        fill_random(3);
        run_load(8'd3, ref_xor(), 1'b1, 5);
        fill_random(2);
        run_load(8'd2, ref_xor(), 1'b0, -1);

        // Random programs, some with a corrupted checksum.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 8);
            fill_random(n);
            cs = ref_xor();
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            run_load(8'(n), cs, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4*n-1)) : -1);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
